// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, defaults and width helper for the keypad scanner
// Purpose: scanner FSM state enum, default parameter values, and the
//          width function used for code, row, column and counter fields.
// Ports:   none (package).
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam int DEF_NROWS    = 4;
  localparam int DEF_NCOLS    = 4;
  localparam int DEF_SCAN_DIV = 16384;
  localparam int DEF_DB_SCANS = 4;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int code_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_sync.sv
// rtl/key_sync.sv - two-flop synchronizer for the active-low column inputs
// Purpose: brings the asynchronous column sense lines into the clk domain.
// Ports:   clk   - clock
//          rstn  - asynchronous active-low reset (flops reset to all ones = idle)
//          d     - raw column inputs
//          q     - synchronized column inputs
module key_sync
  import keypad_pkg::*;
#(
  parameter int WIDTH = DEF_NCOLS
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - row-scanning matrix keypad controller with debounce and code handshake
// Purpose: drives one row low at a time, debounces the lowest pressed column,
//          emits row*NCOLS+col through a valid/ready handshake, flags lost presses.
// Ports:   clk, rstn     - clock, asynchronous active-low reset
//          row_o         - one-cold active-low row drive
//          col_i         - active-low column sense (asynchronous)
//          key_valid_o   - key code available
//          key_ready_i   - consumer accepts code
//          key_code_o    - row*NCOLS + col
//          key_down_o    - debounced key held
//          overrun_o     - one-cycle pulse when a confirmed press is dropped
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int NROWS    = DEF_NROWS,
  parameter int NCOLS    = DEF_NCOLS,
  parameter int SCAN_DIV = DEF_SCAN_DIV,
  parameter int DB_SCANS = DEF_DB_SCANS
) (
  input  logic                                clk,
  input  logic                                rstn,
  output logic [NROWS-1:0]                    row_o,
  input  logic [NCOLS-1:0]                    col_i,
  output logic                                key_valid_o,
  input  logic                                key_ready_i,
  output logic [code_width(NROWS*NCOLS)-1:0]  key_code_o,
  output logic                                key_down_o,
  output logic                                overrun_o
);

  localparam int CW = code_width(NROWS*NCOLS);
  localparam int RW = code_width(NROWS);
  localparam int LW = code_width(NCOLS);
  localparam int DW = code_width(SCAN_DIV);
  localparam int SW = code_width(DB_SCANS + 1);

  state_t          state, state_n;
  logic [NCOLS-1:0] col_s;
  logic [DW-1:0]   div;
  logic            tick;
  logic [RW-1:0]   row_idx, row_nx;
  logic [LW-1:0]   lat_col, low_col;
  logic [SW-1:0]   cnt, cnt_n, cnt_inc;
  logic            any_low, adv, latch, confirm;
  logic [CW-1:0]   code_next;

  key_sync #(.WIDTH(NCOLS)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (col_i),
    .q    (col_s)
  );

  // Row period: the sample at the end of each period sees settled, synchronized columns.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     div <= '0;
    else if (tick) div <= '0;
    else           div <= div + DW'(1);
  end
  assign tick = (div == DW'(SCAN_DIV - 1));

  // Lowest-index low column wins when several keys share the active row.
  always_comb begin
    low_col = '0;
    for (int i = NCOLS - 1; i >= 0; i--) begin
      if (!col_s[i]) low_col = LW'(i);
    end
  end
  assign any_low = ~&col_s;

  assign cnt_inc   = (cnt >= SW'(DB_SCANS)) ? SW'(DB_SCANS) : cnt + SW'(1);
  assign row_nx    = (row_idx == RW'(NROWS - 1)) ? '0 : row_idx + RW'(1);
  assign code_next = CW'(row_idx) * CW'(NCOLS) + CW'(low_col);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= SCAN;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    adv     = 1'b0;
    latch   = 1'b0;
    confirm = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          if (any_low) begin
            latch = 1'b1;
            cnt_n = SW'(1);
            if (DB_SCANS == 1) begin
              confirm = 1'b1;
              state_n = PRESSED;
            end else begin
              state_n = DEBOUNCE;
            end
          end else begin
            adv = 1'b1;
          end
        end
        DEBOUNCE: begin
          if (any_low && low_col == lat_col) begin
            cnt_n = cnt_inc;
            if (cnt_inc == SW'(DB_SCANS)) begin
              confirm = 1'b1;
              state_n = PRESSED;
            end
          end else begin
            cnt_n   = '0;
            adv     = 1'b1;
            state_n = SCAN;
          end
        end
        PRESSED: begin
          // Only the latched column matters here; other keys are ignored.
          if (col_s[lat_col]) begin
            cnt_n = SW'(1);
            if (DB_SCANS == 1) begin
              adv     = 1'b1;
              state_n = SCAN;
            end else begin
              state_n = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (col_s[lat_col]) begin
            cnt_n = cnt_inc;
            if (cnt_inc == SW'(DB_SCANS)) begin
              adv     = 1'b1;
              state_n = SCAN;
            end
          end else begin
            state_n = PRESSED;
          end
        end
        default: state_n = SCAN;
      endcase
    end
  end

  always_comb begin
    row_o          = '1;
    row_o[row_idx] = 1'b0;
    key_down_o     = (state == PRESSED) || (state == RELEASE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_idx     <= '0;
      lat_col     <= '0;
      cnt         <= '0;
      key_valid_o <= 1'b0;
      key_code_o  <= '0;
      overrun_o   <= 1'b0;
    end else begin
      cnt <= cnt_n;
      if (adv)   row_idx <= row_nx;
      if (latch) lat_col <= low_col;
      // A held, unaccepted code is kept; the new press is dropped and flagged.
      overrun_o <= confirm && key_valid_o && !key_ready_i;
      if (confirm && !(key_valid_o && !key_ready_i)) begin
        key_valid_o <= 1'b1;
        key_code_o  <= code_next;
      end else if (key_ready_i) begin
        key_valid_o <= 1'b0;
      end
    end
  end

endmodule
